// File: rtl/fir_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fir_decim_pkg
// Brief   : Shared constants, result types and requantiser for fir_decim_quant
// Revision: 1.0
// ============================================================================
package fir_decim_pkg;

    // Generic accumulator width; comfortably wider than any legal intermediate
    localparam int c_ACC_W = 64;
    localparam logic signed [c_ACC_W-1:0] c_ONE = 64'sd1;

    localparam int c_DEF_IN_INTE_WL  = 4;
    localparam int c_DEF_IN_FRAC_WL  = 12;
    localparam int c_DEF_OUT_INTE_WL = 2;
    localparam int c_DEF_OUT_FRAC_WL = 8;
    localparam int c_DEF_OUT_W       = c_DEF_OUT_INTE_WL + c_DEF_OUT_FRAC_WL;

    function automatic int calc_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    function automatic int calc_mid_w(input int in_inte, input int in_frac, input int out_frac);
        int s;
        s = in_frac - out_frac;
        return in_inte + in_frac + ((s < 0) ? -s : 0) + 1;
    endfunction

    localparam int c_DEF_SHIFT = calc_shift(c_DEF_IN_FRAC_WL, c_DEF_OUT_FRAC_WL);
    localparam int c_DEF_MID_W = calc_mid_w(c_DEF_IN_INTE_WL, c_DEF_IN_FRAC_WL, c_DEF_OUT_FRAC_WL);

    typedef logic signed [c_DEF_OUT_W-1:0] sample_t;

    typedef struct packed {
        logic signed [c_ACC_W-1:0] value;
        logic                      sat;
    } requant_t;

    // Round half toward +inf, rescale by 'shift', then clamp to an out_w-bit signed range
    function automatic requant_t requant_sat(input logic signed [c_ACC_W-1:0] x,
                                             input int shift,
                                             input int out_w);
        requant_t r;
        logic signed [c_ACC_W-1:0] v;
        logic signed [c_ACC_W-1:0] hi;
        logic signed [c_ACC_W-1:0] lo;
        if (shift > 0) begin
            v = (x + (c_ONE <<< (shift - 1))) >>> shift;
        end else begin
            v = x <<< (-shift);
        end
        hi = (c_ONE <<< (out_w - 1)) - c_ONE;
        lo = -hi - c_ONE;
        r.sat = 1'b0;
        r.value = v;
        if (v > hi) begin
            r.sat   = 1'b1;
            r.value = hi;
        end else if (v < lo) begin
            r.sat   = 1'b1;
            r.value = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_decim_quant_if.sv
`default_nettype none
// ============================================================================
// Module  : fir_decim_quant_if
// Brief   : FIR sample input and valid/ready output bundle of fir_decim_quant
// Revision: 1.0
// ============================================================================
interface fir_decim_quant_if #(
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 12,
    parameter int OUT_INTE_WL = 2,
    parameter int OUT_FRAC_WL = 8
);
    logic signed [IN_INTE_WL-1:-IN_FRAC_WL]   data_in;
    logic                                     in_valid;
    logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] data_out;
    logic                                     out_valid;
    logic                                     out_ready;
    logic                                     drop_flag;

    modport slave (
        input  data_in,
        input  in_valid,
        input  out_ready,
        output data_out,
        output out_valid,
        output drop_flag
    );

    modport master (
        output data_in,
        output in_valid,
        output out_ready,
        input  data_out,
        input  out_valid,
        input  drop_flag
    );
endinterface
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fir_sync_fifo
// Brief   : First-word fall-through synchronous FIFO, power-of-two depth
// Revision: 1.0
// ============================================================================
module fir_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]    count_q, count_d;
    logic             w_wr_en;
    logic             w_rd_en;

    always_comb begin
        w_rd_en  = pop && !empty;
        // A full FIFO still accepts a write when the head leaves in the same cycle
        w_wr_en  = push && (!full || w_rd_en);
        wr_ptr_d = w_wr_en ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_rd_en ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_wr_en, w_rd_en})
            2'b10:   count_d = count_q + (c_AW + 1)'(1);
            2'b01:   count_d = count_q - (c_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == c_FULL);
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fir_decim_quant.sv
`default_nettype none
// ============================================================================
// Module  : fir_decim_quant
// Brief   : Decimate FIR output, requantise with rounding/saturation, buffer
//           in a valid/ready FIFO. Optional macro FIR_DECIM_SAT_CNT_EN adds
//           a saturating 16-bit sat_cnt output.
// Revision: 1.0
// ============================================================================
module fir_decim_quant
    import fir_decim_pkg::*;
#(
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 12,
    parameter int OUT_INTE_WL = 2,
    parameter int OUT_FRAC_WL = 8,
    parameter int DECIM       = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    fir_decim_quant_if.slave bus
`ifdef FIR_DECIM_SAT_CNT_EN
    ,
    output logic [15:0] sat_cnt
`endif
);
    localparam int         c_SHIFT   = calc_shift(IN_FRAC_WL, OUT_FRAC_WL);
    localparam int         c_OUT_W   = OUT_INTE_WL + OUT_FRAC_WL;
    localparam logic [3:0] c_PH_LAST = 4'(DECIM - 1);

    logic [3:0]                phase_q, phase_d;
    logic                      q_valid_q, q_valid_d;
    logic [c_OUT_W-1:0]        q_data_q, q_data_d;
    logic                      drop_q, drop_d;
    logic                      w_keep;
    logic signed [c_ACC_W-1:0] w_ext;
    requant_t                  w_rq;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [c_OUT_W-1:0]        w_rdata;
    logic                      w_unused_bits;

    always_comb begin
        w_keep = bus.in_valid && (phase_q == 4'd0);
        w_ext  = c_ACC_W'(bus.data_in);
        w_rq   = requant_sat(w_ext, c_SHIFT, c_OUT_W);

        phase_d = phase_q;
        if (bus.in_valid) begin
            phase_d = (phase_q == c_PH_LAST) ? 4'd0 : phase_q + 4'd1;
        end

        q_valid_d = w_keep;
        q_data_d  = w_keep ? w_rq.value[c_OUT_W-1:0] : q_data_q;

        w_pop  = !w_empty && bus.out_ready;
        // Sticky: a stage-Q push that a full, non-draining FIFO cannot take
        drop_d = drop_q | (q_valid_q && w_full && !w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= 4'd0;
            q_valid_q <= 1'b0;
            q_data_q  <= '0;
            drop_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            q_valid_q <= q_valid_d;
            q_data_q  <= q_data_d;
            drop_q    <= drop_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (c_OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_valid_q),
        .wdata (q_data_q),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.out_valid = !w_empty;
    assign bus.data_out  = w_empty ? '0 : w_rdata;
    assign bus.drop_flag = drop_q;

`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (w_keep && w_rq.sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt       = sat_cnt_q;
    assign w_unused_bits = ^w_rq.value[c_ACC_W-1:c_OUT_W];
`else
    assign w_unused_bits = ^{w_rq.sat, w_rq.value[c_ACC_W-1:c_OUT_W]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_quant.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_decim_quant
// Brief   : Three DUTs (DECIM 2/3/1) fed one stream, checked against a model
// Revision: 1.0
// ============================================================================
module tb_fir_decim_quant;
    localparam int  c_N     = 3;
    localparam int  c_DEPTH = 4;
    localparam int  c_OUT_W = 10;
    localparam int  c_HI    = 511;
    localparam int  c_LO    = -512;
    localparam real c_SCALE = 256.0 / 4096.0;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] data_in;
    logic        out_ready;

    logic             obs_valid [c_N];
    logic [c_OUT_W-1:0] obs_data [c_N];
    logic             obs_drop  [c_N];
`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0]      obs_satc  [c_N];
`endif

    int n_tests;
    int n_fail;

    int               m_phase [c_N];
    bit               m_qv    [c_N];
    logic [c_OUT_W-1:0] m_qd  [c_N];
    logic [c_OUT_W-1:0] m_fifo [c_N][c_DEPTH];
    int               m_cnt   [c_N];
    bit               m_drop  [c_N];
    int               m_satc  [c_N];

    for (genvar k = 0; k < c_N; k++) begin : g_inst
        localparam int c_D = (k == 0) ? 2 : ((k == 1) ? 3 : 1);
        fir_decim_quant_if #(.IN_INTE_WL(4), .IN_FRAC_WL(12),
                             .OUT_INTE_WL(2), .OUT_FRAC_WL(8)) bus ();
        assign bus.data_in   = data_in;
        assign bus.in_valid  = in_valid;
        assign bus.out_ready = out_ready;
        assign obs_valid[k]  = bus.out_valid;
        assign obs_data[k]   = bus.data_out;
        assign obs_drop[k]   = bus.drop_flag;

        fir_decim_quant #(
            .IN_INTE_WL(4), .IN_FRAC_WL(12), .OUT_INTE_WL(2), .OUT_FRAC_WL(8),
            .DECIM(c_D), .FIFO_DEPTH(c_DEPTH)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
`ifdef FIR_DECIM_SAT_CNT_EN
            ,
            .sat_cnt (obs_satc[k])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dec_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
    endfunction

    // Real-valued rescale, round half up, clamp to the 2.8 range
    function automatic int mdl_quant(input logic [15:0] raw, output bit sat);
        real v;
        int  q;
        v   = $itor($signed(raw)) * c_SCALE;
        q   = $rtoi($floor(v + 0.5));
        sat = 1'b0;
        if (q > c_HI) begin
            q = c_HI; sat = 1'b1;
        end else if (q < c_LO) begin
            q = c_LO; sat = 1'b1;
        end
        return q;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < c_N; k++) begin
            m_phase[k] = 0; m_qv[k] = 0; m_qd[k] = '0;
            m_cnt[k] = 0; m_drop[k] = 0; m_satc[k] = 0;
        end
    endtask

    // Compare outputs, apply inputs, advance the model across one rising edge
    task automatic step(input bit r, input bit iv, input logic [15:0] din, input bit rdy);
        bit pop;
        bit full;
        bit sat;
        int q;
        for (int k = 0; k < c_N; k++) begin
            check_eq($sformatf("valid%0d", k), 32'(obs_valid[k]), 32'(m_cnt[k] > 0));
            if (m_cnt[k] > 0)
                check_eq($sformatf("data%0d", k), 32'(obs_data[k]), 32'(m_fifo[k][0]));
            check_eq($sformatf("drop%0d", k), 32'(obs_drop[k]), 32'(m_drop[k]));
`ifdef FIR_DECIM_SAT_CNT_EN
            check_eq($sformatf("satc%0d", k), 32'(obs_satc[k]), 32'(m_satc[k]));
`endif
        end
        rst = r; in_valid = iv; data_in = din; out_ready = rdy;
        if (r) begin
            mdl_reset();
        end else begin
            for (int k = 0; k < c_N; k++) begin
                pop  = (m_cnt[k] > 0) && rdy;
                full = (m_cnt[k] == c_DEPTH);
                if (pop) begin
                    for (int i = 0; i < c_DEPTH - 1; i++) m_fifo[k][i] = m_fifo[k][i+1];
                    m_cnt[k]--;
                end
                if (m_qv[k]) begin
                    if (full && !pop) m_drop[k] = 1'b1;
                    else begin
                        m_fifo[k][m_cnt[k]] = m_qd[k];
                        m_cnt[k]++;
                    end
                end
                m_qv[k] = iv && (m_phase[k] == 0);
                if (m_qv[k]) begin
                    q = mdl_quant(din, sat);
                    m_qd[k] = c_OUT_W'(q);
                    if (sat && m_satc[k] < 65535) m_satc[k]++;
                end
                if (iv) m_phase[k] = (m_phase[k] + 1) % dec_of(k);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, rdy);
    endtask

    bit          r_rst;
    bit          r_iv;
    bit          r_rdy;
    logic [15:0] r_din;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < c_N; k++)
            check_eq($sformatf("rst_data%0d", k), 32'(obs_data[k]), 32'd0);

        // Basic conversion: 1.0 appears two edges after sampling
        step(1'b0, 1'b1, 16'h1000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check_eq("basic_valid", 32'(obs_valid[0]), 32'd1);
        check_eq("basic_data", 32'(obs_data[0]), 32'h100);
        idle(3, 1'b1);

        // Rounding edges, each followed by a discarded sample on DECIM=2
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 16'h0008, 1'b1); step(1'b0, 1'b1, 16'h1234, 1'b1);
        step(1'b0, 1'b1, 16'hFFF8, 1'b1); step(1'b0, 1'b1, 16'h1234, 1'b1);
        step(1'b0, 1'b1, 16'hFFF7, 1'b1); step(1'b0, 1'b1, 16'h1234, 1'b1);
        idle(4, 1'b1);

        // Saturation at both rails
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 16'h7000, 1'b1); step(1'b0, 1'b1, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 16'h8000, 1'b1); step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(4, 1'b1);
`ifdef FIR_DECIM_SAT_CNT_EN
        check_eq("sat_cnt_pair", 32'(obs_satc[0]), 32'd2);
`endif

        // Decimation: values quantising to 1..8 on a contiguous stream
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i * 16), 1'b1);
        idle(6, 1'b1);

        // Backpressure: 12 contiguous inputs with the consumer stalled
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        idle(3, 1'b0);
        check_eq("bp_drop", 32'(obs_drop[0]), 32'd1);
        check_eq("bp_full", 32'(obs_valid[0]), 32'd1);
        idle(8, 1'b1);

        // Reset with three stored entries and phase 1 on the DECIM=2 instance
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("midrst_valid", 32'(obs_valid[0]), 32'd0);
        check_eq("midrst_drop", 32'(obs_drop[0]), 32'd0);
        step(1'b0, 1'b1, 16'h0200, 1'b1);
        idle(3, 1'b1);

        // Randomised traffic with occasional resets and rail values
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_iv  = ($urandom_range(0, 9) < 7);
            r_rdy = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 7))
                0:       r_din = 16'h7FFF;
                1:       r_din = 16'h8000;
                2:       r_din = 16'($urandom_range(0, 31)) - 16'd16;
                default: r_din = 16'($urandom);
            endcase
            step(r_rst, r_iv, r_din, r_rdy);
        end
        idle(8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
